// File: rtl/tlb_refill_ctrl.sv
// Shares one TLB between the fetch (port 0) and data (port 1) ports, walking a single-level
// page table on a miss. Define TLB_CTRL_RR_EN for round-robin instead of fixed priority.
module tlb_refill_ctrl #(
    parameter int unsigned entries   = 4,
    parameter int unsigned bit_count = 32,
    parameter int unsigned page_size = 4096
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    req0_valid,
    input  logic [bit_count-1:0]                    req0_vaddr,
    input  logic                                    req1_valid,
    input  logic [bit_count-1:0]                    req1_vaddr,
    output logic                                    resp0_valid,
    output logic                                    resp1_valid,
    output logic [bit_count-1:0]                    resp_paddr,
    output logic                                    resp_fault,
    input  logic [bit_count-1:0]                    ptbr,
    output logic                                    tlb_lookup_valid,
    output logic [bit_count-1:0]                    tlb_vaddr,
    input  logic                                    tlb_hit,
    input  logic [bit_count-1:0]                    tlb_paddr,
    output logic                                    tlb_fill_valid,
    output logic [$clog2(entries)-1:0]              tlb_fill_idx,
    output logic [bit_count-$clog2(page_size)-1:0]  tlb_fill_vpn,
    output logic [bit_count-$clog2(page_size)-1:0]  tlb_fill_ppn,
    output logic                                    mem_req,
    output logic [bit_count-1:0]                    mem_addr,
    input  logic                                    mem_ack,
    input  logic [bit_count-1:0]                    mem_rdata
);

    localparam int unsigned OW = $clog2(page_size);
    localparam int unsigned PW = bit_count - OW;
    localparam int unsigned IW = $clog2(entries);

    typedef enum logic [2:0] {StIdle, StLookup, StCheck, StWalk, StFill, StResp} state_e;

    state_e               state_q;
    logic                 port_q;
    logic [bit_count-1:0] vaddr_q;
    logic [PW-1:0]        ppn_q;
    logic [IW-1:0]        fill_ptr_q;
    logic                 resp0_q;
    logic                 resp1_q;
    logic [bit_count-1:0] paddr_q;
    logic                 fault_q;
    logic                 lookup_q;
    logic                 fill_q;
    logic                 mem_req_q;
    logic [bit_count-1:0] mem_addr_q;
`ifdef TLB_CTRL_RR_EN
    logic                 prio_q;
`endif

    logic                 gnt_port;
    logic [bit_count-1:0] pte_addr;
    logic                 unused_rdata;

    always_comb begin
        gnt_port = 1'b0;
`ifdef TLB_CTRL_RR_EN
        if (req0_valid && req1_valid) begin
            gnt_port = prio_q;
        end else begin
            gnt_port = req1_valid;
        end
`else
        // Port 0 always wins; port 1 is only taken when port 0 is idle.
        gnt_port = !req0_valid;
`endif
    end

    assign pte_addr     = ptbr + bit_count'({vaddr_q[bit_count-1:OW], 2'b00});
    assign unused_rdata = ^mem_rdata[OW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            port_q     <= 1'b0;
            vaddr_q    <= '0;
            ppn_q      <= '0;
            fill_ptr_q <= '0;
            resp0_q    <= 1'b0;
            resp1_q    <= 1'b0;
            paddr_q    <= '0;
            fault_q    <= 1'b0;
            lookup_q   <= 1'b0;
            fill_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef TLB_CTRL_RR_EN
            prio_q     <= 1'b0;
`endif
        end else begin
            resp0_q  <= 1'b0;
            resp1_q  <= 1'b0;
            lookup_q <= 1'b0;
            fill_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_valid || req1_valid) begin
                        port_q   <= gnt_port;
                        vaddr_q  <= gnt_port ? req1_vaddr : req0_vaddr;
                        lookup_q <= 1'b1;
                        state_q  <= StLookup;
`ifdef TLB_CTRL_RR_EN
                        prio_q   <= !gnt_port;
`endif
                    end
                end
                StLookup: state_q <= StCheck;
                StCheck: begin
                    if (tlb_hit) begin
                        paddr_q <= tlb_paddr;
                        fault_q <= 1'b0;
                        resp0_q <= !port_q;
                        resp1_q <= port_q;
                        state_q <= StResp;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pte_addr;
                        state_q    <= StWalk;
                    end
                end
                StWalk: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (mem_rdata[0]) begin
                            ppn_q   <= mem_rdata[bit_count-1:OW];
                            fill_q  <= 1'b1;
                            state_q <= StFill;
                        end else begin
                            fault_q <= 1'b1;
                            paddr_q <= '0;
                            resp0_q <= !port_q;
                            resp1_q <= port_q;
                            state_q <= StResp;
                        end
                    end
                end
                StFill: begin
                    fill_ptr_q <= fill_ptr_q + IW'(1);
                    paddr_q    <= {ppn_q, vaddr_q[OW-1:0]};
                    fault_q    <= 1'b0;
                    resp0_q    <= !port_q;
                    resp1_q    <= port_q;
                    state_q    <= StResp;
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp0_valid      = resp0_q;
    assign resp1_valid      = resp1_q;
    assign resp_paddr       = paddr_q;
    assign resp_fault       = fault_q;
    assign tlb_lookup_valid = lookup_q;
    assign tlb_vaddr        = vaddr_q;
    assign tlb_fill_valid   = fill_q;
    assign tlb_fill_idx     = fill_ptr_q;
    assign tlb_fill_vpn     = vaddr_q[bit_count-1:OW];
    assign tlb_fill_ppn     = ppn_q;
    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Randomized bench for tlb_refill_ctrl with a transaction-level reference model, an external
// TLB array and a page-table memory. Honours TLB_CTRL_RR_EN for the arbitration expectations.
module tb_tlb_refill_ctrl;

    localparam int ENT = 4;
`ifdef TLB_CTRL_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_vaddr, req1_vaddr;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp_paddr;
    logic        resp_fault;
    logic [31:0] ptbr;
    logic        tlb_lookup_valid;
    logic [31:0] tlb_vaddr;
    logic        tlb_hit;
    logic [31:0] tlb_paddr;
    logic        tlb_fill_valid;
    logic [1:0]  tlb_fill_idx;
    logic [19:0] tlb_fill_vpn, tlb_fill_ppn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    tlb_refill_ctrl #(.entries(ENT), .bit_count(32), .page_size(4096)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_vaddr(req0_vaddr),
        .req1_valid(req1_valid), .req1_vaddr(req1_vaddr),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_paddr(resp_paddr), .resp_fault(resp_fault), .ptbr(ptbr),
        .tlb_lookup_valid(tlb_lookup_valid), .tlb_vaddr(tlb_vaddr),
        .tlb_hit(tlb_hit), .tlb_paddr(tlb_paddr),
        .tlb_fill_valid(tlb_fill_valid), .tlb_fill_idx(tlb_fill_idx),
        .tlb_fill_vpn(tlb_fill_vpn), .tlb_fill_ppn(tlb_fill_ppn),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] pt [logic [19:0]];
    logic [19:0] etlb_vpn [ENT];
    logic [19:0] etlb_ppn [ENT];
    logic        etlb_v   [ENT];
    logic [19:0] rtlb_vpn [ENT];
    logic [19:0] rtlb_ppn [ENT];
    logic        rtlb_v   [ENT];
    int          ref_ptr;
    logic        ref_prio;

    logic        force_hit;
    logic [31:0] force_paddr;
    int          mem_wait;
    logic [31:0] exp_mem_addr;
    int          fill_cnt, memreq_cnt, resp_cnt;
    logic [1:0]  last_idx;
    logic [19:0] last_vpn, last_ppn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // External TLB array: result appears the cycle after the lookup strobe.
    initial begin
        logic        pend;
        logic [31:0] va;
        pend = 1'b0; va = '0; tlb_hit = 1'b0; tlb_paddr = '0;
        forever begin
            @(negedge clk);
            tlb_hit = 1'b0;
            if (pend) begin
                if (force_hit) begin
                    tlb_hit = 1'b1; tlb_paddr = force_paddr;
                end else begin
                    for (int i = 0; i < ENT; i++) begin
                        if (etlb_v[i] && etlb_vpn[i] == va[31:12]) begin
                            tlb_hit = 1'b1; tlb_paddr = {etlb_ppn[i], va[11:0]};
                        end
                    end
                end
            end
            pend = tlb_lookup_valid;
            va   = tlb_vaddr;
        end
    end

    // Page-table memory with a programmable ack delay.
    initial begin
        int          wcnt;
        logic [31:0] off;
        wcnt = 0; off = '0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wcnt >= mem_wait) begin
                    off       = mem_addr - ptbr;
                    mem_ack   = 1'b1;
                    mem_rdata = pt.exists(off[21:2]) ? pt[off[21:2]] : 32'h0;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        fill_cnt = 0; memreq_cnt = 0; resp_cnt = 0;
        last_idx = '0; last_vpn = '0; last_ppn = '0;
        forever begin
            @(negedge clk);
            if (tlb_fill_valid) begin
                fill_cnt++;
                last_idx = tlb_fill_idx; last_vpn = tlb_fill_vpn; last_ppn = tlb_fill_ppn;
                etlb_v[tlb_fill_idx]   = 1'b1;
                etlb_vpn[tlb_fill_idx] = tlb_fill_vpn;
                etlb_ppn[tlb_fill_idx] = tlb_fill_ppn;
            end
            if (mem_req) begin
                memreq_cnt++;
                check_eq("mem_addr", mem_addr, exp_mem_addr);
            end
            if (resp0_valid || resp1_valid) resp_cnt++;
        end
    end

    // One request through the reference model: predicts hit/miss, fill slot, result and latency.
    task automatic run_req(input logic port, input logic [31:0] va, input int wt);
        logic [19:0] vpn;
        logic [31:0] pte, exp_pa, got_pa;
        bit          hit, exp_fault, exp_fill, got, got_port, got_fault;
        int          exp_lat, exp_idx, lat, f0, m0, r0;
        vpn = va[31:12];
        hit = force_hit; exp_pa = force_paddr;
        exp_fault = 1'b0; exp_fill = 1'b0; exp_idx = 0;
        exp_mem_addr = ptbr + 32'(vpn) * 4;
        if (!force_hit) begin
            for (int i = 0; i < ENT; i++) begin
                if (rtlb_v[i] && rtlb_vpn[i] == vpn) begin
                    hit = 1'b1; exp_pa = {rtlb_ppn[i], va[11:0]};
                end
            end
        end
        if (hit) begin
            exp_lat = 3;
        end else begin
            pte = pt.exists(vpn) ? pt[vpn] : 32'h0;
            if (pte[0]) begin
                exp_fill = 1'b1; exp_idx = ref_ptr; exp_pa = {pte[31:12], va[11:0]};
                rtlb_v[ref_ptr] = 1'b1; rtlb_vpn[ref_ptr] = vpn; rtlb_ppn[ref_ptr] = pte[31:12];
                ref_ptr = (ref_ptr + 1) % ENT;
                exp_lat = 5 + wt;
            end else begin
                exp_fault = 1'b1; exp_pa = 32'h0; exp_lat = 4 + wt;
            end
        end
        mem_wait = wt; f0 = fill_cnt; m0 = memreq_cnt; r0 = resp_cnt;
        if (port) begin req1_valid = 1'b1; req1_vaddr = va; end
        else      begin req0_valid = 1'b1; req0_vaddr = va; end
        lat = 0; got = 1'b0; got_port = 1'b0; got_pa = '0; got_fault = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (resp0_valid || resp1_valid) begin
                got = 1'b1; got_port = resp1_valid; got_pa = resp_paddr; got_fault = resp_fault;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("latency", lat, exp_lat);
        check_eq("resp_port", {31'b0, got_port}, {31'b0, port});
        check_eq("resp_paddr", got_pa, exp_pa);
        check_eq("resp_fault", {31'b0, got_fault}, {31'b0, exp_fault});
        @(negedge clk);
        check_eq("resp_after", {30'b0, resp1_valid, resp0_valid}, 32'h0);
        check_eq("resp_count", resp_cnt - r0, 1);
        check_eq("fill_count", fill_cnt - f0, {31'b0, exp_fill});
        check_eq("memreq_cycles", memreq_cnt - m0, hit ? 0 : wt + 1);
        if (exp_fill) begin
            check_eq("fill_idx", {30'b0, last_idx}, exp_idx);
            check_eq("fill_vpn", {12'b0, last_vpn}, {12'b0, vpn});
            check_eq("fill_ppn", {12'b0, last_ppn}, {12'b0, exp_pa[31:12]});
        end
        ref_prio = !port;
    endtask

    initial begin
        int          n, lat, since;
        logic [19:0] vpn;
        logic        exp_port;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; req0_vaddr = '0; req1_vaddr = '0;
        ptbr = 32'h0001_0000; force_hit = 1'b0; force_paddr = '0; mem_wait = 0;
        exp_mem_addr = '0; ref_ptr = 0; ref_prio = 1'b0;
        for (int i = 0; i < ENT; i++) begin
            etlb_v[i] = 1'b0; etlb_vpn[i] = '0; etlb_ppn[i] = '0;
            rtlb_v[i] = 1'b0; rtlb_vpn[i] = '0; rtlb_ppn[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_resp", {30'b0, resp1_valid, resp0_valid}, 32'h0);
        check_eq("rst_ctrl", {29'b0, tlb_lookup_valid, tlb_fill_valid, mem_req}, 32'h0);
        check_eq("rst_paddr", resp_paddr, 32'h0);
        check_eq("rst_fault", {31'b0, resp_fault}, 32'h0);
        rst = 1'b0;

        force_hit = 1'b1; force_paddr = 32'h1234_5ABC;
        run_req(1'b0, 32'h0040_3ABC, 0);
        force_hit = 1'b0;

        pt[20'h00403] = 32'h7777_7001;
        run_req(1'b1, 32'h0040_3ABC, 0);
        check_eq("t2_fill_ppn", {12'b0, last_ppn}, 32'h0007_7777);
        check_eq("t2_fill_vpn", {12'b0, last_vpn}, 32'h0000_0403);

        for (int k = 4; k < 8; k++) begin
            vpn = 20'h00400 + 20'(k);
            pt[vpn] = {20'(32'h0AB00 + k), 12'h001};
            run_req(k[0], {vpn, 12'h123}, k - 4);
        end
        check_eq("wrap_fill_idx", {30'b0, last_idx}, 32'h0);

        pt[20'h00500] = 32'h0;
        run_req(1'b0, 32'h0050_0FFF, 5);

        for (int k = 0; k < 8; k++) begin
            vpn = 20'h00100 + 20'(k);
            pt[vpn] = {20'($urandom), 11'($urandom), 1'($urandom_range(0, 3) != 0)};
        end
        for (int k = 0; k < 40; k++) begin
            vpn = 20'h00100 + 20'($urandom_range(0, 7));
            run_req(1'($urandom_range(0, 1)), {vpn, 12'($urandom)}, $urandom_range(0, 3));
        end

        // Both ports held valid, all hits: grant order and back-to-back spacing.
        force_hit = 1'b1; force_paddr = 32'hCAFE_0123;
        req0_valid = 1'b1; req0_vaddr = 32'h0000_1000;
        req1_valid = 1'b1; req1_vaddr = 32'h0000_2000;
        n = 0; lat = 0; since = 0;
        while (n < 4 && lat < 60) begin
            @(negedge clk);
            lat++; since++;
            if (resp0_valid || resp1_valid) begin
                exp_port = RrEn ? ref_prio : 1'b0;
                check_eq("arb_port", {30'b0, resp1_valid, resp0_valid},
                         exp_port ? 32'h2 : 32'h1);
                check_eq("arb_spacing", since, n == 0 ? 3 : 4);
                ref_prio = !exp_port;
                since = 0; n++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("arb_grants", n, 4);
        @(negedge clk);
        force_hit = 1'b0;

        // Reset two cycles into a page walk.
        vpn = 20'h55555;
        pt[vpn] = 32'h3210_F001;
        exp_mem_addr = ptbr + 32'(vpn) * 4;
        mem_wait = 100;
        req0_valid = 1'b1; req0_vaddr = {vpn, 12'h777};
        lat = 0;
        while (!mem_req && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("walk_start", lat, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_walk_memreq", {31'b0, mem_req}, 32'h0);
        check_eq("rst_walk_resp", {30'b0, resp1_valid, resp0_valid}, 32'h0);
        rst = 1'b0; req0_valid = 1'b0;
        ref_ptr = 0; ref_prio = 1'b0;
        run_req(1'b1, {vpn, 12'h777}, 0);
        check_eq("rst_fill_idx", {30'b0, last_idx}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
